// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per channel, a square wave and a one-cycle tick at each period start.
// Outputs decode from channel flops, so they change one clk edge after an input change; divisor writes take effect at the next period boundary.
module clk_div_multi #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 32,
    parameter int unsigned DIV_INIT = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                div_load,
    input  logic [3:0]          div_sel,
    input  logic [WIDTH-1:0]    div_val,
    output logic [CHANNELS-1:0] clk_N,
    output logic [CHANNELS-1:0] tick
);

    // A divisor below 2 cannot produce both a high and a low phase.
    localparam logic [WIDTH-1:0] DIV_RST = (DIV_INIT < 2) ? WIDTH'(2) : WIDTH'(DIV_INIT);

    logic [WIDTH-1:0] div_clamped;

    assign div_clamped = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] dcur_q, dcur_d;
        logic [WIDTH-1:0] dpend_q, dpend_d;
        logic             active_q, active_d;
        logic             pend_q, pend_d;
        logic             load_hit;
        logic             wrap;
        logic             boundary;
        logic [WIDTH-1:0] half;

        // Out-of-range selects never match any channel index, so they are ignored.
        assign load_hit = div_load && (div_sel == 4'(i));
        assign wrap     = (cnt_q == (dcur_q - WIDTH'(1)));
        assign boundary = en[i] && (!active_q || wrap);

        always_comb begin
            cnt_d    = cnt_q;
            active_d = active_q;
            dcur_d   = dcur_q;
            dpend_d  = dpend_q;
            pend_d   = pend_q;

            if (!en[i]) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else if (boundary) begin
                cnt_d    = '0;
                active_d = 1'b1;
                if (pend_q) begin
                    dcur_d = dpend_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end

            // A write coinciding with a boundary uses the old pending value there and
            // re-arms pend, so the new divisor waits for the following boundary.
            if (load_hit) begin
                dpend_d = div_clamped;
                pend_d  = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
                dcur_q   <= DIV_RST;
                dpend_q  <= DIV_RST;
                pend_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                active_q <= active_d;
                dcur_q   <= dcur_d;
                dpend_q  <= dpend_d;
                pend_q   <= pend_d;
            end
        end

        // ceil(D/2) without a WIDTH+1 adder: cannot overflow even for D = 2^WIDTH-1.
        assign half     = (dcur_q >> 1) + WIDTH'(dcur_q[0]);
        assign tick[i]  = active_q && (cnt_q == '0);
        assign clk_N[i] = active_q && (cnt_q < half);
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with CHANNELS=4, WIDTH=16, DIV_INIT=4.
// Each cycle's clk_N/tick vectors are hand-derived; bit i is channel i.
module tb_clk_div_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        div_load;
    logic [3:0]  div_sel;
    logic [15:0] div_val;
    logic [3:0]  clk_N;
    logic [3:0]  tick;

    int vectors;
    int miscompares;

    clk_div_multi #(
        .CHANNELS(4),
        .WIDTH   (16),
        .DIV_INIT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_load(div_load),
        .div_sel (div_sel),
        .div_val (div_val),
        .clk_N   (clk_N),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] exp_clk, input logic [3:0] exp_tick);
        @(posedge clk);
        #1;
        chk({tag, ".clk_N"}, clk_N, exp_clk);
        chk({tag, ".tick"}, tick, exp_tick);
    endtask

    task automatic load(input logic [3:0] sel, input logic [15:0] val);
        div_load = 1'b1;
        div_sel  = sel;
        div_val  = val;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        en          = 4'b0001;
        div_load    = 1'b0;
        div_sel     = 4'd0;
        div_val     = 16'd0;

        cyc("reset_c0", 4'b0000, 4'b0000);
        cyc("reset_c1", 4'b0000, 4'b0000);
        rst = 1'b0;

        // Channel 0 from reset release, D=4: 1,1,0,0 with tick on each rise.
        for (int k = 0; k < 2; k++) begin
            cyc("d4_p0", 4'b0001, 4'b0001);
            cyc("d4_p1", 4'b0001, 4'b0000);
            cyc("d4_p2", 4'b0000, 4'b0000);
            cyc("d4_p3", 4'b0000, 4'b0000);
        end
        cyc("d4_c9", 4'b0001, 4'b0001);

        // Load 5 mid-period: the running 4-cycle period completes first.
        load(4'd0, 16'd5);
        cyc("ld5_c10", 4'b0001, 4'b0000);
        div_load = 1'b0;
        cyc("ld5_c11", 4'b0000, 4'b0000);
        cyc("ld5_c12", 4'b0000, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            cyc("d5_p0", 4'b0001, 4'b0001);
            cyc("d5_p1", 4'b0001, 4'b0000);
            cyc("d5_p2", 4'b0001, 4'b0000);
            cyc("d5_p3", 4'b0000, 4'b0000);
            cyc("d5_p4", 4'b0000, 4'b0000);
        end
        cyc("d5_c23", 4'b0001, 4'b0001);

        // Channel 1 alone: loads of 0 then 1 both clamp to D=2.
        en = 4'b0010;
        cyc("ch1_c24", 4'b0010, 4'b0010);
        load(4'd1, 16'd0);
        cyc("ch1_c25", 4'b0010, 4'b0000);
        div_val = 16'd1;
        cyc("ch1_c26", 4'b0000, 4'b0000);
        div_load = 1'b0;
        cyc("ch1_c27", 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            cyc("d2_hi", 4'b0010, 4'b0010);
            cyc("d2_lo", 4'b0000, 4'b0000);
        end

        // Channel 2: drop enable mid-period, load 3 while disabled, re-enable.
        en = 4'b0100;
        cyc("ch2_c34", 4'b0100, 4'b0100);
        cyc("ch2_c35", 4'b0100, 4'b0000);
        en = 4'b0000;
        cyc("ch2_off0", 4'b0000, 4'b0000);
        load(4'd2, 16'd3);
        cyc("ch2_off1", 4'b0000, 4'b0000);
        div_load = 1'b0;
        cyc("ch2_off2", 4'b0000, 4'b0000);
        en = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            cyc("d3_p0", 4'b0100, 4'b0100);
            cyc("d3_p1", 4'b0100, 4'b0000);
            cyc("d3_p2", 4'b0000, 4'b0000);
        end

        // Channels 1 (D=2) and 3 (D=4) together; out-of-range selects 4 and 7 are ignored.
        en = 4'b1010;
        cyc("oor_c45", 4'b1010, 4'b1010);
        cyc("oor_c46", 4'b1000, 4'b0000);
        load(4'd4, 16'd7);
        cyc("oor_c47", 4'b0010, 4'b0010);
        div_sel = 4'd7;
        cyc("oor_c48", 4'b0000, 4'b0000);
        div_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc("oor_p0", 4'b1010, 4'b1010);
            cyc("oor_p1", 4'b1000, 4'b0000);
            cyc("oor_p2", 4'b0010, 4'b0010);
            cyc("oor_p3", 4'b0000, 4'b0000);
        end

        // Load 9 to channel 3 on its boundary edge, then 6: only 6 lands, one boundary later.
        load(4'd3, 16'd9);
        cyc("same_c57", 4'b1010, 4'b1010);
        div_val = 16'd6;
        cyc("same_c58", 4'b1000, 4'b0000);
        div_load = 1'b0;
        cyc("same_c59", 4'b0010, 4'b0010);
        cyc("same_c60", 4'b0000, 4'b0000);
        cyc("d6_c61", 4'b1010, 4'b1010);
        cyc("d6_c62", 4'b1000, 4'b0000);
        cyc("d6_c63", 4'b1010, 4'b0010);
        cyc("d6_c64", 4'b0000, 4'b0000);
        cyc("d6_c65", 4'b0010, 4'b0010);
        cyc("d6_c66", 4'b0000, 4'b0000);
        cyc("d6_c67", 4'b1010, 4'b1010);

        // All on: channels 0 and 2 restart, channels 1 and 3 are one cycle into their periods.
        en = 4'b1111;
        cyc("all_c68", 4'b1101, 4'b0101);

        // Asynchronous reset between clock edges, then restart in phase at D=4.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.clk_N", clk_N, 4'b0000);
        chk("async_rst.tick", tick, 4'b0000);
        cyc("rst_hold", 4'b0000, 4'b0000);
        rst = 1'b0;
        cyc("restart_p0", 4'b1111, 4'b1111);
        cyc("restart_p1", 4'b1111, 4'b0000);
        cyc("restart_p2", 4'b0000, 4'b0000);
        cyc("restart_p3", 4'b0000, 4'b0000);
        cyc("restart_p4", 4'b1111, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
